// File: rtl/tile_result_uart_tx.sv
// tile_result_uart_tx: drain end of the systolic array.
// Result words from the edge tile are buffered in a small circular FIFO and
// sent to the host as UART 8N1 frames, least-significant byte first.
// TXD is registered; BUSY covers both an active frame and queued words.
module tile_result_uart_tx #(
  parameter int Bitwidth     = 16,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          RES_VALID,
  input  logic [Bitwidth-1:0]           RES_DATA,
  output logic                          TXD,
  output logic                          BUSY,
  output logic                          DROP,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int NBYTES = Bitwidth / 8;
  localparam int BDW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BYW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [Bitwidth-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [CW-1:0]       r_count;
  logic                r_drop;

  // Serializer state
  state_t              r_state;
  logic [BDW-1:0]      r_baud;
  logic [2:0]          r_bit_idx;
  logic [BYW-1:0]      r_byte_idx;
  logic [Bitwidth-1:0] r_shift;
  logic                r_txd;

  // Next-state / control from the FSM
  state_t              w_state_nxt;
  logic [BDW-1:0]      w_baud_nxt;
  logic [2:0]          w_bit_nxt;
  logic [BYW-1:0]      w_byte_nxt;
  logic                w_txd_nxt;
  logic                w_pop;
  logic                w_load;
  logic                w_shift;

  logic                w_baud_done;
  logic                w_fifo_nempty;
  logic                w_full;
  logic                w_push;
  logic                w_drop_evt;
  logic                w_last_byte;

  assign w_baud_done   = (r_baud == BDW'(CLKS_PER_BIT - 1));
  assign w_fifo_nempty = (r_count != '0);
  assign w_full        = (r_count == CW'(FIFO_DEPTH));
  assign w_last_byte   = (r_byte_idx == BYW'(NBYTES - 1));

  // A pop on the same edge frees a slot, so a write into a full FIFO is
  // accepted when the serializer is taking the head word at that edge.
  assign w_push     = RES_VALID && (!w_full || w_pop);
  assign w_drop_evt = RES_VALID && w_full && !w_pop;

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state, bit timing and line value
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit_idx;
    w_byte_nxt  = r_byte_idx;
    w_txd_nxt   = r_txd;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_txd_nxt  = 1'b1;
        w_baud_nxt = '0;
        if (w_fifo_nempty) begin
          w_pop       = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = S_START;
          w_txd_nxt   = 1'b0;
          w_byte_nxt  = '0;
        end
      end
      S_START: begin
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_state_nxt = S_DATA;
          w_bit_nxt   = 3'd0;
          w_txd_nxt   = r_shift[0];
          w_shift     = 1'b1;
        end else begin
          w_baud_nxt = r_baud + BDW'(1);
        end
      end
      S_DATA: begin
        if (w_baud_done) begin
          w_baud_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
            w_txd_nxt   = 1'b1;
          end else begin
            w_bit_nxt = r_bit_idx + 3'd1;
            w_txd_nxt = r_shift[0];
            w_shift   = 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud + BDW'(1);
        end
      end
      S_STOP: begin
        if (w_baud_done) begin
          w_baud_nxt = '0;
          if (!w_last_byte) begin
            // Next byte of the same word already sits in the low bits.
            w_state_nxt = S_START;
            w_txd_nxt   = 1'b0;
            w_byte_nxt  = r_byte_idx + BYW'(1);
          end else if (w_fifo_nempty) begin
            w_pop       = 1'b1;
            w_load      = 1'b1;
            w_state_nxt = S_START;
            w_txd_nxt   = 1'b0;
            w_byte_nxt  = '0;
          end else begin
            w_state_nxt = S_IDLE;
            w_txd_nxt   = 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud + BDW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_txd_nxt   = 1'b1;
        w_baud_nxt  = '0;
      end
    endcase
  end

  // Serializer control registers; reset forces the line idle immediately
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_baud     <= '0;
      r_bit_idx  <= 3'd0;
      r_byte_idx <= '0;
      r_txd      <= 1'b1;
    end else begin
      r_baud     <= w_baud_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_byte_idx <= w_byte_nxt;
      r_txd      <= w_txd_nxt;
    end
  end

  // Shift register: load the head word on pop, shift right after each data bit
  always_ff @(posedge CLK) begin
    if (w_load) begin
      r_shift <= r_mem[r_rptr];
    end else if (w_shift) begin
      r_shift <= r_shift >> 1;
    end
  end

  // FIFO storage write
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wptr] <= RES_DATA;
    end
  end

  // FIFO pointers (natural wrap, depth is a power of two), occupancy and sticky drop
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_drop  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop_evt) begin
        r_drop <= 1'b1;
      end
    end
  end

  assign TXD        = r_txd;
  assign DROP       = r_drop;
  assign FIFO_COUNT = r_count;
  assign BUSY       = (r_state != S_IDLE) || (r_count != '0);

endmodule

// File: tb/tb_tile_result_uart_tx.sv
// Bench for tile_result_uart_tx (Bitwidth=16, CLKS_PER_BIT=4, FIFO_DEPTH=8).
// Model: a queue of pending words plus a queue of line samples per cycle.
module tb_tile_result_uart_tx;

  localparam int BW    = 16;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          CLK;
  logic          RST_N;
  logic          RES_VALID;
  logic [BW-1:0] RES_DATA;
  logic          TXD;
  logic          BUSY;
  logic          DROP;
  logic [CW-1:0] FIFO_COUNT;

  int checks;
  int failures;

  tile_result_uart_tx #(
    .Bitwidth    (BW),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .RES_VALID (RES_VALID),
    .RES_DATA  (RES_DATA),
    .TXD       (TXD),
    .BUSY      (BUSY),
    .DROP      (DROP),
    .FIFO_COUNT(FIFO_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [BW-1:0] m_fifo[$];
  logic          m_line[$];
  logic          m_drop;
  logic [BW-1:0] m_word;
  logic [7:0]    m_byte;
  logic          m_bit;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_fifo.delete();
      m_line.delete();
      m_drop = 1'b0;
    end else begin
      // the sample shown during the cycle just ended is consumed
      if (m_line.size() != 0) void'(m_line.pop_front());
      // nothing left on the line: take the next word, if any
      if (m_line.size() == 0 && m_fifo.size() != 0) begin
        m_word = m_fifo.pop_front();
        for (int b = 0; b < BW / 8; b++) begin
          m_byte = m_word[8*b +: 8];
          for (int s = 0; s < 10; s++) begin
            if (s == 0)      m_bit = 1'b0;
            else if (s == 9) m_bit = 1'b1;
            else             m_bit = m_byte[s-1];
            for (int c = 0; c < CPB; c++) m_line.push_back(m_bit);
          end
        end
      end
      if (RES_VALID) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(RES_DATA);
        else m_drop = 1'b1;
      end
    end
  end

  function automatic logic exp_txd();
    return (m_line.size() != 0) ? m_line[0] : 1'b1;
  endfunction

  // cycle-by-cycle comparison against the model
  always @(negedge CLK) begin
    chk("cyc_txd",   TXD,        exp_txd());
    chk("cyc_busy",  BUSY,       (m_line.size() != 0) || (m_fifo.size() != 0));
    chk("cyc_drop",  DROP,       m_drop);
    chk("cyc_count", FIFO_COUNT, m_fifo.size());
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_word(input logic [BW-1:0] d);
    RES_VALID = 1'b1;
    RES_DATA  = d;
    tick();
    RES_VALID = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (BUSY && n < budget) begin
      tick();
      n++;
    end
    chk(name, BUSY, 1'b0);
  endtask

  task automatic pulse_reset();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  logic [7:0] a5_lo;
  logic       low_seen;

  initial begin
    RST_N     = 1'b0;
    RES_VALID = 1'b0;
    RES_DATA  = '0;
    a5_lo     = 8'h5A;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_txd",   TXD,        1'b1);
    chk("rst_busy",  BUSY,       1'b0);
    chk("rst_drop",  DROP,       1'b0);
    chk("rst_count", FIFO_COUNT, 0);
    RST_N = 1'b1;
    tick();

    // ---- single word 0xA55A written at edge 0 ----
    write_word(16'hA55A);
    chk("sw_e0_txd", TXD, 1'b1);
    chk("sw_e0_cnt", FIFO_COUNT, 1);
    tick();
    chk("sw_start", TXD, 1'b0);
    chk("sw_e1_cnt", FIFO_COUNT, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) tick();
      chk($sformatf("sw_bit%0d", i), TXD, a5_lo[i]);
    end
    repeat (CPB) tick();
    chk("sw_stop", TXD, 1'b1);
    repeat (CPB) tick();
    chk("sw_start2", TXD, 1'b0);
    repeat (39) tick();
    chk("sw_busy_e80", BUSY, 1'b1);
    tick();
    chk("sw_busy_e81", BUSY, 1'b0);
    repeat (3) tick();

    // ---- back-to-back words ----
    write_word(16'h1234);
    write_word(16'hBEEF);
    repeat (80) tick();
    chk("b2b_start_w1", TXD, 1'b0);
    repeat (79) tick();
    chk("b2b_busy_e160", BUSY, 1'b1);
    tick();
    chk("b2b_busy_e161", BUSY, 1'b0);
    repeat (3) tick();

    // ---- overflow: ten writes on consecutive edges ----
    for (int i = 0; i < 10; i++) begin
      RES_VALID = 1'b1;
      RES_DATA  = 16'(i);
      tick();
      if (i == 8) chk("ovf_drop_e8", DROP, 1'b0);
    end
    RES_VALID = 1'b0;
    chk("ovf_drop_e9", DROP, 1'b1);
    chk("ovf_cnt_e9", FIFO_COUNT, 8);
    wait_idle("ovf_drain", 2000);
    chk("ovf_drop_sticky", DROP, 1'b1);
    pulse_reset();
    chk("ovf_drop_cleared", DROP, 1'b0);

    // ---- wrap-around: 20 words, one per frame time ----
    for (int k = 0; k < 20; k++) begin
      write_word(16'(k * 16'h0F1D + 16'h0301));
      chk("wrap_cnt_le1", FIFO_COUNT <= 1, 1'b1);
      repeat (79) tick();
    end
    wait_idle("wrap_drain", 400);
    chk("wrap_drop", DROP, 1'b0);
    repeat (2) tick();

    // ---- full FIFO with simultaneous pop ----
    for (int i = 0; i < 9; i++) write_word(16'hC000 + 16'(i));
    chk("full_cnt_e8", FIFO_COUNT, 8);
    repeat (72) tick();
    RES_VALID = 1'b1;
    RES_DATA  = 16'hD00D;
    tick();
    chk("full_pop_cnt", FIFO_COUNT, 8);
    chk("full_pop_drop", DROP, 1'b0);
    RES_DATA = 16'hDEAD;
    tick();
    RES_VALID = 1'b0;
    chk("full_nopop_drop", DROP, 1'b1);
    chk("full_nopop_cnt", FIFO_COUNT, 8);
    wait_idle("full_drain", 2000);
    pulse_reset();

    // ---- reset asserted mid-frame ----
    write_word(16'h0000);
    repeat (10) tick();
    chk("mrst_pre_txd", TXD, 1'b0);
    #2;
    RST_N = 1'b0;
    #1;
    chk("mrst_txd",   TXD,        1'b1);
    chk("mrst_busy",  BUSY,       1'b0);
    chk("mrst_drop",  DROP,       1'b0);
    chk("mrst_count", FIFO_COUNT, 0);
    @(posedge CLK);
    #3;
    RST_N = 1'b1;
    low_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (TXD !== 1'b1) low_seen = 1'b1;
    end
    chk("mrst_no_output", low_seen, 1'b0);
    chk("mrst_busy_after", BUSY, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
